// File: rtl/gpu_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gpu_mem_arbiter_pkg
//  Purpose  : Shared GPU package. Holds the camera descriptor used by the
//             tile pipeline and the default sizing of the memory arbiter.
//  Contents : camera_t, GPU_NUM_MASTERS, GPU_MAX_PENDING, id_width()
//  Revision : 1.0 - initial release
// ============================================================================
package gpu_mem_arbiter_pkg;

  // Camera descriptor shared by the tile controllers.
  typedef struct packed {
    logic [15:0] pos_x;
    logic [15:0] pos_y;
    logic [15:0] pos_z;
    logic [7:0]  fov;
  } camera_t;

  // Default arbiter sizing: tile controllers sharing one port, and the
  // number of reads that may be accepted before the first answer returns.
  localparam int GPU_NUM_MASTERS = 4;
  localparam int GPU_MAX_PENDING = 4;

  // Width of a requester ID; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpu_mem_arbiter_rsp_id_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : rsp_id_fifo
//  Purpose  : Records the requester ID of every accepted read so that the
//             in-order read responses can be routed back to their owner.
//  Ports    : clock, reset      - rising-edge clock, synchronous reset
//             push, push_id     - append an ID at the tail
//             pop               - drop the head entry
//             full, empty, head - status and current head ID
//  Revision : 1.0 - initial release
// ============================================================================
module rsp_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_id,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_id;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/gpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : gpu_mem_arbiter
//  Purpose  : Round-robin arbiter letting NUM_MASTERS Avalon-MM tile
//             controllers share one memory master port. One transfer per
//             grant; reads are tracked so responses return to their owner.
//  Ports    : clock, reset                         - clock, sync reset
//             s_address/s_writedata/s_write/s_read - per-requester commands
//             s_waitrequest/s_readdata/
//             s_readdatavalid                      - per-requester responses
//             m1_address/m1_writedata/
//             m1_write/m1_read                     - shared command
//             m1_waitrequest/m1_readdata/
//             m1_readdatavalid                     - shared response
//             rsp_error                            - sticky orphan-response flag
//  Revision : 1.0 - initial release
// ============================================================================
module gpu_mem_arbiter
  import gpu_mem_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = GPU_NUM_MASTERS,
  parameter int ADDR_BITS   = 32,
  parameter int DATA_BITS   = 8,
  parameter int MAX_PENDING = GPU_MAX_PENDING
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_MASTERS-1:0][ADDR_BITS-1:0] s_address,
  input  logic [NUM_MASTERS-1:0][DATA_BITS-1:0] s_writedata,
  input  logic [NUM_MASTERS-1:0]                s_write,
  input  logic [NUM_MASTERS-1:0]                s_read,
  output logic [NUM_MASTERS-1:0]                s_waitrequest,
  output logic [NUM_MASTERS-1:0][DATA_BITS-1:0] s_readdata,
  output logic [NUM_MASTERS-1:0]                s_readdatavalid,
  output logic [ADDR_BITS-1:0]                  m1_address,
  output logic [DATA_BITS-1:0]                  m1_writedata,
  output logic                                  m1_write,
  output logic                                  m1_read,
  input  logic                                  m1_waitrequest,
  input  logic [DATA_BITS-1:0]                  m1_readdata,
  input  logic                                  m1_readdatavalid,
  output logic                                  rsp_error
);

  localparam int ID_W = id_width(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] req;
  logic [ID_W-1:0]        last_grant;
  logic                   locked;
  logic [ID_W-1:0]        lock_id;
  logic [ID_W-1:0]        winner;
  logic [ID_W-1:0]        cand;
  logic                   granted;
  logic                   win_is_write;
  logic                   win_is_read;
  logic                   read_blocked;
  logic                   forwarded;
  logic                   accepted;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [ID_W-1:0]        fifo_head;
  logic                   rsp_error_q;

  assign req = s_read | s_write;

  // Winner selection: a stalled transfer keeps its grant; otherwise scan
  // starting just after the last accepted requester.
  always_comb begin
    winner  = lock_id;
    granted = 1'b0;
    cand    = '0;
    if (locked) begin
      granted = req[lock_id];
    end else begin
      for (int k = 1; k <= NUM_MASTERS; k++) begin
        cand = ID_W'((int'(last_grant) + k) % NUM_MASTERS);
        if (!granted && req[cand]) begin
          winner  = cand;
          granted = 1'b1;
        end
      end
    end
    if (reset) begin
      granted = 1'b0;
    end
  end

  // Read+write together is treated as a write only.
  assign win_is_write = s_write[winner];
  assign win_is_read  = s_read[winner] & ~s_write[winner];

  assign pop          = m1_readdatavalid & ~fifo_empty & ~reset;
  // A read may not go out when its ID has nowhere to go this cycle.
  assign read_blocked = win_is_read & fifo_full & ~pop;
  assign forwarded    = granted & ~read_blocked;
  assign accepted     = forwarded & ~m1_waitrequest;
  assign push         = accepted & win_is_read;

  assign m1_read      = forwarded & win_is_read;
  assign m1_write     = forwarded & win_is_write;
  assign m1_address   = forwarded ? s_address[winner]   : '0;
  assign m1_writedata = forwarded ? s_writedata[winner] : '0;

  always_comb begin
    s_waitrequest = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (reset) begin
        s_waitrequest[i] = 1'b1;
      end else if (req[i]) begin
        s_waitrequest[i] = (forwarded && (winner == ID_W'(i))) ? m1_waitrequest : 1'b1;
      end
    end
  end

  // Zero-latency routing of the returning read to the oldest outstanding ID.
  always_comb begin
    s_readdata      = '0;
    s_readdatavalid = '0;
    if (pop) begin
      s_readdata[fifo_head]      = m1_readdata;
      s_readdatavalid[fifo_head] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant  <= ID_W'(NUM_MASTERS - 1);
      locked      <= 1'b0;
      lock_id     <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      if (accepted) begin
        last_grant <= winner;
        locked     <= 1'b0;
      end else if (forwarded) begin
        locked     <= 1'b1;
        lock_id    <= winner;
      end else begin
        locked     <= 1'b0;
      end
      if (m1_readdatavalid && fifo_empty) begin
        rsp_error_q <= 1'b1;
      end
    end
  end

  assign rsp_error = rsp_error_q;

  rsp_id_fifo #(
    .DEPTH (MAX_PENDING),
    .WIDTH (ID_W)
  ) u_rsp_id_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .push_id (winner),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

endmodule
`default_nettype wire

// File: tb/tb_gpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpu_mem_arbiter
//  Purpose  : Self-checking bench for gpu_mem_arbiter: directed scenarios
//             followed by randomized traffic, all compared every cycle to a
//             queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gpu_mem_arbiter;

  localparam int NM = 4;
  localparam int AB = 32;
  localparam int DB = 8;
  localparam int MP = 4;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NM-1:0][AB-1:0] s_address;
  logic [NM-1:0][DB-1:0] s_writedata;
  logic [NM-1:0]        s_write;
  logic [NM-1:0]        s_read;
  logic [NM-1:0]        s_waitrequest;
  logic [NM-1:0][DB-1:0] s_readdata;
  logic [NM-1:0]        s_readdatavalid;
  logic [AB-1:0]        m1_address;
  logic [DB-1:0]        m1_writedata;
  logic                 m1_write;
  logic                 m1_read;
  logic                 m1_waitrequest;
  logic [DB-1:0]        m1_readdata;
  logic                 m1_readdatavalid;
  logic                 rsp_error;

  always #5 clock = ~clock;

  gpu_mem_arbiter #(
    .NUM_MASTERS (NM),
    .ADDR_BITS   (AB),
    .DATA_BITS   (DB),
    .MAX_PENDING (MP)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .s_address        (s_address),
    .s_writedata      (s_writedata),
    .s_write          (s_write),
    .s_read           (s_read),
    .s_waitrequest    (s_waitrequest),
    .s_readdata       (s_readdata),
    .s_readdatavalid  (s_readdatavalid),
    .m1_address       (m1_address),
    .m1_writedata     (m1_writedata),
    .m1_write         (m1_write),
    .m1_read          (m1_read),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .rsp_error        (rsp_error)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int mdl_last;
  bit mdl_locked;
  int mdl_lock_id;
  int mdl_q[$];
  bit mdl_err;

  // Predictions for the current cycle
  bit e_granted, e_fwd, e_accept, e_pop, e_is_rd;
  int e_win;
  logic [AB-1:0]        e_addr;
  logic [DB-1:0]        e_wdata;
  logic                 e_rd, e_wr;
  logic [NM-1:0]        e_wait, e_rdv;
  logic [NM-1:0][DB-1:0] e_rdata;

  logic [NM-1:0] hold;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    logic [NM-1:0] req;
    int c;
    req       = s_read | s_write;
    e_granted = 1'b0;
    e_win     = 0;
    if (!reset) begin
      if (mdl_locked) begin
        e_win     = mdl_lock_id;
        e_granted = req[mdl_lock_id];
      end else begin
        for (int k = 1; k <= NM; k++) begin
          c = (mdl_last + k) % NM;
          if (!e_granted && req[c]) begin
            e_win     = c;
            e_granted = 1'b1;
          end
        end
      end
    end
    e_is_rd  = s_read[e_win] && !s_write[e_win];
    e_pop    = !reset && m1_readdatavalid && (mdl_q.size() > 0);
    e_fwd    = e_granted && !(e_is_rd && (mdl_q.size() == MP) && !e_pop);
    e_accept = e_fwd && !m1_waitrequest;
    e_rd     = e_fwd && e_is_rd;
    e_wr     = e_fwd && s_write[e_win];
    e_addr   = e_fwd ? s_address[e_win]   : '0;
    e_wdata  = e_fwd ? s_writedata[e_win] : '0;
    for (int i = 0; i < NM; i++) begin
      if (reset)        e_wait[i] = 1'b1;
      else if (!req[i]) e_wait[i] = 1'b0;
      else              e_wait[i] = (e_fwd && i == e_win) ? m1_waitrequest : 1'b1;
    end
    e_rdv   = '0;
    e_rdata = '0;
    if (e_pop) begin
      e_rdv[mdl_q[0]]   = 1'b1;
      e_rdata[mdl_q[0]] = m1_readdata;
    end
  endtask

  task automatic model_commit();
    if (reset) begin
      mdl_last   = NM - 1;
      mdl_locked = 1'b0;
      mdl_q.delete();
      mdl_err    = 1'b0;
    end else begin
      if (e_accept) begin
        mdl_last   = e_win;
        mdl_locked = 1'b0;
      end else if (e_fwd) begin
        mdl_locked  = 1'b1;
        mdl_lock_id = e_win;
      end else begin
        mdl_locked = 1'b0;
      end
      if (m1_readdatavalid && mdl_q.size() == 0) mdl_err = 1'b1;
      if (e_pop) void'(mdl_q.pop_front());
      if (e_accept && e_is_rd) mdl_q.push_back(e_win);
    end
  endtask

  // Inputs are already driven; let them settle and compare against the model.
  task automatic settle(input string tag);
    #1;
    model_eval();
    chk({tag, ".m1_read"},         64'(m1_read),         64'(e_rd));
    chk({tag, ".m1_write"},        64'(m1_write),        64'(e_wr));
    chk({tag, ".m1_address"},      64'(m1_address),      64'(e_addr));
    chk({tag, ".m1_writedata"},    64'(m1_writedata),    64'(e_wdata));
    chk({tag, ".s_waitrequest"},   64'(s_waitrequest),   64'(e_wait));
    chk({tag, ".s_readdatavalid"}, 64'(s_readdatavalid), 64'(e_rdv));
    chk({tag, ".s_readdata"},      64'(s_readdata),      64'(e_rdata));
    chk({tag, ".rsp_error"},       64'(rsp_error),       64'(mdl_err));
  endtask

  task automatic advance();
    @(posedge clock);
    model_commit();
    #1;
  endtask

  task automatic idle();
    s_read           = '0;
    s_write          = '0;
    s_address        = '0;
    s_writedata      = '0;
    m1_waitrequest   = 1'b0;
    m1_readdata      = '0;
    m1_readdatavalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Bring-up: first reset edge seeds both DUT and model.
    idle();
    reset  = 1'b1;
    s_read = '1;
    @(posedge clock);
    model_commit();
    #1;

    // Outputs while reset is held with requests present
    settle("reset");
    chk("reset_wait_all", 64'(s_waitrequest), 64'hF);
    chk("reset_m1_read",  64'(m1_read),       64'h0);
    advance();
    reset = 1'b0;

    // Round robin from reset, each read answered one cycle after acceptance
    for (int i = 0; i < NM; i++) s_address[i] = 32'h1000 + i;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) s_read = '0;
      m1_readdatavalid = (k > 0);
      m1_readdata      = 8'(8'h10 + k);
      settle("rr");
      if (k < 5) chk("rr_grant_addr", 64'(m1_address), 64'(32'h1000 + (k % 4)));
      if (k > 0) begin
        chk("rr_route_valid", 64'(s_readdatavalid), 64'(1 << ((k - 1) % 4)));
        chk("rr_route_data",  64'(s_readdata),
            64'(32'(8'h10 + k) << (8 * ((k - 1) % 4))));
      end
      advance();
    end
    idle();

    // Write from master 1 beside a read from master 0
    s_read[0]      = 1'b1;
    s_address[0]   = 32'h4000;
    s_write[1]     = 1'b1;
    s_address[1]   = 32'h100;
    s_writedata[1] = 8'hA5;
    settle("wr");
    chk("wr_m1_write",     64'(m1_write),     64'h1);
    chk("wr_m1_address",   64'(m1_address),   64'h100);
    chk("wr_m1_writedata", 64'(m1_writedata), 64'hA5);
    advance();
    s_write[1] = 1'b0;
    settle("wr_rd");
    chk("wr_then_read_addr", 64'(m1_address), 64'h4000);
    advance();
    s_read[0]        = 1'b0;
    m1_readdatavalid = 1'b1;
    m1_readdata      = 8'h5A;
    settle("wr_rsp");
    chk("wr_no_push_route", 64'(s_readdatavalid), 64'h1);
    advance();
    idle();

    // Master 2 stalled five cycles while master 3 waits
    s_read[2]    = 1'b1;
    s_address[2] = 32'h2222;
    s_read[3]    = 1'b1;
    s_address[3] = 32'h3333;
    for (int k = 0; k < 6; k++) begin
      m1_waitrequest = (k < 5);
      settle("lock");
      chk("lock_addr_held", 64'(m1_address), 64'h2222);
      chk("lock_m3_waits",  64'(s_waitrequest[3]), 64'h1);
      advance();
    end
    s_read[2]      = 1'b0;
    m1_waitrequest = 1'b0;
    settle("lock_next");
    chk("lock_m3_granted", 64'(m1_address), 64'h3333);
    advance();
    s_read[3]        = 1'b0;
    m1_readdatavalid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      settle("lock_drain");
      chk("lock_drain_route", 64'(s_readdatavalid), 64'(4 << k));
      advance();
    end
    idle();

    // Response FIFO full: fifth read stalls until a response frees a slot
    s_read = '1;
    for (int i = 0; i < NM; i++) s_address[i] = 32'h5000 + i;
    for (int k = 0; k < 4; k++) begin
      settle("fill");
      chk("fill_grant", 64'(m1_address), 64'(32'h5000 + k));
      advance();
      s_read[k] = 1'b0;
    end
    s_read[0] = 1'b1;
    settle("full");
    chk("full_read_suppressed", 64'(m1_read),          64'h0);
    chk("full_winner_waits",    64'(s_waitrequest[0]), 64'h1);
    advance();
    m1_readdatavalid = 1'b1;
    m1_readdata      = 8'h77;
    settle("full_pushpop");
    chk("pushpop_read_fwd", 64'(m1_read),         64'h1);
    chk("pushpop_route",    64'(s_readdatavalid), 64'h1);
    advance();
    m1_readdatavalid = 1'b0;
    s_read           = 4'b0010;
    settle("still_full");
    chk("still_full_stall", 64'(m1_read), 64'h0);
    advance();
    s_read           = '0;
    m1_readdatavalid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      m1_readdata = 8'(8'h80 + j);
      settle("full_drain");
      chk("full_drain_route", 64'(s_readdatavalid), 64'(1 << ((j + 1) % 4)));
      advance();
    end
    idle();

    // Orphan response
    m1_readdatavalid = 1'b1;
    settle("orphan");
    chk("orphan_no_valid", 64'(s_readdatavalid), 64'h0);
    advance();
    m1_readdatavalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle("orphan_sticky");
      chk("orphan_err_sticky", 64'(rsp_error), 64'h1);
      advance();
    end

    // Reset with three reads in flight
    reset = 1'b1;
    advance();
    reset  = 1'b0;
    s_read = 4'b0111;
    for (int i = 0; i < NM; i++) s_address[i] = 32'h6000 + i;
    for (int k = 0; k < 3; k++) begin
      settle("pend");
      advance();
      s_read[k] = 1'b0;
    end
    reset     = 1'b1;
    s_read[3] = 1'b1;
    settle("midreset");
    chk("midreset_wait_all", 64'(s_waitrequest), 64'hF);
    chk("midreset_no_read",  64'(m1_read),       64'h0);
    advance();
    reset            = 1'b0;
    s_read           = '0;
    m1_readdatavalid = 1'b1;
    settle("late_rsp");
    chk("late_rsp_dropped", 64'(s_readdatavalid), 64'h0);
    advance();
    m1_readdatavalid = 1'b0;
    s_read           = '1;
    settle("post_reset_grant");
    chk("post_reset_m0", 64'(m1_address), 64'h6000);
    chk("late_rsp_err",  64'(rsp_error),  64'h1);
    advance();
    idle();

    // Randomized traffic, commands held while waited on
    reset = 1'b1;
    advance();
    reset = 1'b0;
    hold  = '0;
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NM; i++) begin
        if (!hold[i]) begin
          int r;
          r              = $urandom_range(0, 9);
          s_read[i]      = (r < 3) || (r == 5);
          s_write[i]     = (r >= 3) && (r <= 5);
          s_address[i]   = $urandom;
          s_writedata[i] = 8'($urandom);
        end
      end
      m1_waitrequest   = ($urandom_range(0, 3) == 0);
      m1_readdatavalid = ($urandom_range(0, 2) == 0);
      m1_readdata      = 8'($urandom);
      settle("rand");
      hold = (s_read | s_write) & e_wait;
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpu_mem_arbiter.md
GPU_MEM_ARBITER -- requirements
Module: gpu_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4: number of tile controllers sharing one memory port.
REQ-002 SHALL have parameter ADDR_BITS, default 32: Avalon address width.
REQ-003 SHALL have parameter DATA_BITS, default 8: Avalon data width.
REQ-004 SHALL have parameter MAX_PENDING, default 4: maximum reads accepted but not yet answered.
REQ-005 SHALL have port clock  in  1: single clock; all logic is rising-edge.
REQ-006 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-007 SHALL have ports s_address, s_writedata, s_write, s_read  in  NUM_MASTERS x {ADDR_BITS, DATA_BITS, 1, 1}: per-requester Avalon commands.
REQ-008 SHALL have ports s_waitrequest, s_readdata, s_readdatavalid  out  NUM_MASTERS x {1, DATA_BITS, 1}: per-requester responses.
REQ-009 SHALL have ports m1_address, m1_writedata, m1_write, m1_read  out  {ADDR_BITS, DATA_BITS, 1, 1}: shared master command.
REQ-010 SHALL have ports m1_waitrequest, m1_readdata, m1_readdatavalid  in  {1, DATA_BITS, 1}: shared master response.
REQ-011 SHALL have port rsp_error  out  1: sticky flag, set on readdatavalid with no read outstanding.

Function
REQ-012 SHALL treat requester i as requesting when s_read[i] or s_write[i] is high.
REQ-013 SHALL, when unlocked, grant combinationally in the same cycle: winner = first requester in round-robin order starting at last_grant+1 mod NUM_MASTERS.
REQ-014 SHALL forward the winner's address, writedata, read and write to m1_*; when nothing is granted, m1_read = m1_write = 0 and m1_address = m1_writedata = 0.
REQ-015 SHALL drive s_waitrequest[i]=1 for every requesting non-winner and s_waitrequest[winner]=m1_waitrequest; non-requesters see 0.
REQ-016 SHALL lock the grant to the winner from the next cycle while the winner's command is presented with m1_waitrequest=1; the lock ignores all other requesters.
REQ-017 SHALL treat a command as accepted when it is forwarded and m1_waitrequest=0; on acceptance, last_grant <= winner and the lock clears, so re-arbitration happens in the next cycle (one transfer per grant).
REQ-018 SHALL, on acceptance of a read, push the winner ID into a response-ID FIFO of depth MAX_PENDING; accepted writes push nothing.
REQ-019 SHALL, when the FIFO is full and no pop occurs in the same cycle, suppress any read winner: m1_read=0 and s_waitrequest[winner]=1; a write winner is still forwarded.
REQ-020 SHALL, on m1_readdatavalid, pop the FIFO head and drive s_readdatavalid[head]=1 and s_readdata[head]=m1_readdata in the same cycle (zero latency); all other s_readdatavalid are 0 and all other s_readdata are 0.
REQ-021 SHALL allow a push and a pop in the same cycle when full; occupancy is unchanged.
REQ-022 SHALL, on m1_readdatavalid with the FIFO empty, drop the data and set rsp_error; rsp_error clears only on reset.
REQ-023 SHALL forward only the write when a requester asserts both s_read and s_write; that command is counted as a write.
REQ-024 SHALL wrap last_grant from NUM_MASTERS-1 to 0, and SHALL size the occupancy counter as $clog2(MAX_PENDING+1) bits.

Reset
REQ-025 SHALL, while reset is high, set last_grant=NUM_MASTERS-1 (so master 0 wins first), clear the lock, flush the FIFO and clear rsp_error.
REQ-026 SHALL, while reset is high, drive m1_read=m1_write=0, all s_readdatavalid=0 and all s_waitrequest=1.
REQ-027 SHALL discard reads still in flight after a reset asserted mid-operation; their late readdatavalid sets rsp_error.

Structure
REQ-028 SHALL take the default NUM_MASTERS and MAX_PENDING constants from the shared gpu package, next to the camera typedef.
REQ-029 SHALL implement the response-ID FIFO as sub-module rsp_id_fifo (parameters: depth, width $clog2(NUM_MASTERS); outputs: full, empty, head).

Verification
REQ-030 SHALL cover: s_read[0..3] all high from reset, m1_waitrequest=0, readdatavalid one cycle after each accept -> grants 0,1,2,3,0, each s_readdatavalid routed to the matching ID.
REQ-031 SHALL cover: master 2 read with m1_waitrequest=1 for 5 cycles while master 3 requests -> m1_address holds master 2's value for all 6 cycles; master 3 is granted in cycle 7.
REQ-032 SHALL cover: 4 reads accepted with no response and a 5th requested -> 5th stalled (m1_read=0); readdatavalid plus the 5th request in the same cycle -> 5th accepted, occupancy stays 4.
REQ-033 SHALL cover: m1_readdatavalid=1 with nothing outstanding -> no s_readdatavalid, rsp_error=1 until reset.
REQ-034 SHALL cover: reset pulsed with 3 reads pending -> FIFO empty, the next grant goes to master 0, and a late readdatavalid sets rsp_error.
REQ-035 SHALL cover: master 1 asserts s_write with s_writedata=0xA5 at address 0x100 while master 0 reads -> write forwarded intact, no FIFO push for the write.
